// File: rtl/sprite_pkg.sv
// Shared constants, class/orientation encodings and field widths for the
// Pac-Man sprite compositor.
package sprite_pkg;

    localparam int SPR_LOG_DEF = 5;
    localparam int X_W         = 10;
    localparam int Y_W         = 9;
    localparam int OR_W        = 2;
    localparam int COL_W       = 12;

    localparam logic [COL_W-1:0] KEY_COLOR_DEF  = 12'h000;
    localparam logic [COL_W-1:0] WALL_COLOR_DEF = 12'hfff;
    localparam logic [COL_W-1:0] BEAN_COLOR_DEF = 12'hff0;

    typedef enum logic [1:0] {
        CLS_BLACK = 2'd0,
        CLS_WALL  = 2'd1,
        CLS_BEAN  = 2'd2,
        CLS_SPR   = 2'd3
    } pix_class_e;

    // Column-major codes (0/1) store the sprite transposed in ROM.
    typedef enum logic [OR_W-1:0] {
        OR_COL_ROW  = 2'd0,
        OR_COL_FLIP = 2'd1,
        OR_ROW_COL  = 2'd2,
        OR_ROW_FLIP = 2'd3
    } orient_e;

endpackage

// File: rtl/sprite_hit.sv
// Combinational bounding-box test and orientation-aware local ROM address
// for one sprite against the current scan pixel.
module sprite_hit
    import sprite_pkg::*;
#(
    parameter int SPR_LOG = SPR_LOG_DEF
) (
    input  logic [X_W-1:0]       x_i,
    input  logic [Y_W-1:0]       y_i,
    input  logic [OR_W-1:0]      orient_i,
    input  logic                 en_i,
    input  logic [Y_W-1:0]       row_i,
    input  logic [X_W-1:0]       col_i,
    output logic                 hit_o,
    output logic [2*SPR_LOG-1:0] local_o
);

    localparam logic [10:0] S = 11'(1 << SPR_LOG);

    logic [10:0]        row_w, col_w, y_w, x_w;
    logic [SPR_LOG-1:0] lr, lc;

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        // 11-bit operands keep Y+S / X+S from wrapping near the screen edge.
        row_w = {2'b00, row_i};
        col_w = {1'b0, col_i};
        y_w   = {2'b00, y_i};
        x_w   = {1'b0, x_i};
        hit_o = en_i && (row_w >= y_w) && (row_w < y_w + S)
                     && (col_w >= x_w) && (col_w < x_w + S);
        lr    = SPR_LOG'(row_i - y_i);
        lc    = SPR_LOG'(col_i - x_i);
        case (orient_i)
            OR_COL_ROW:  local_o = {lc, lr};
            OR_COL_FLIP: local_o = {lc, ~lr};
            OR_ROW_COL:  local_o = {lr, lc};
            default:     local_o = {lr, ~lc};
        endcase
    end

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage pixel compositor: sprite priority/layering, ROM fetch alignment,
// colour-key transparency and sticky Pac-vs-ghost collision flags.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int                 NUM_SPR    = 5,
    parameter int                 SPR_LOG    = SPR_LOG_DEF,
    parameter logic [NUM_SPR-1:0] ABOVE_BEAN = 5'b11110,
    parameter logic [COL_W-1:0]   KEY_COLOR  = KEY_COLOR_DEF,
    parameter logic [COL_W-1:0]   WALL_COLOR = WALL_COLOR_DEF,
    parameter logic [COL_W-1:0]   BEAN_COLOR = BEAN_COLOR_DEF,
    localparam int IDX_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
    localparam int LOC_W = 2 * SPR_LOG,
    localparam int AW    = IDX_W + LOC_W
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    pix_valid,
    input  logic [Y_W-1:0]          row_addr,
    input  logic [X_W-1:0]          col_addr,
    input  logic                    is_wall,
    input  logic                    is_bean,
    input  logic                    over,
    input  logic                    frame_start,
    input  logic [NUM_SPR*X_W-1:0]  spr_x,
    input  logic [NUM_SPR*Y_W-1:0]  spr_y,
    input  logic [NUM_SPR*OR_W-1:0] spr_orient,
    input  logic [NUM_SPR-1:0]      spr_en,
    output logic [AW-1:0]           rom_addr,
    input  logic [COL_W-1:0]        rom_data,
    output logic [COL_W-1:0]        vga_data,
    output logic                    vga_valid,
    output logic [NUM_SPR-1:0]      collide
);

    logic [NUM_SPR*X_W-1:0]  sx_q;
    logic [NUM_SPR*Y_W-1:0]  sy_q;
    logic [NUM_SPR*OR_W-1:0] so_q;
    logic [NUM_SPR-1:0]      se_q;

    logic [NUM_SPR-1:0] hit;
    logic [LOC_W-1:0]   loc [NUM_SPR];

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_hit
        sprite_hit #(.SPR_LOG(SPR_LOG)) u_hit (
            .x_i      (sx_q[i*X_W +: X_W]),
            .y_i      (sy_q[i*Y_W +: Y_W]),
            .orient_i (so_q[i*OR_W +: OR_W]),
            .en_i     (se_q[i]),
            .row_i    (row_addr),
            .col_i    (col_addr),
            .hit_o    (hit[i]),
            .local_o  (loc[i])
        );
    end

    logic               a_found, b_found;
    logic [IDX_W-1:0]   a_idx, b_idx;
    logic [LOC_W-1:0]   a_loc, b_loc;
    pix_class_e         cls_d, cls1_q, cls2_q;
    logic               vld1_q, vld2_q, bean1_q, bean2_q;
    logic [AW-1:0]      rom_addr_d, rom_addr_q;
    logic [NUM_SPR-1:0] coll_set, collide_d, collide_q;
    logic [COL_W-1:0]   vga_data_d, vga_data_q;
    logic               vga_valid_q;

    always_comb begin
        a_found = 1'b0;
        b_found = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        a_loc   = '0;
        b_loc   = '0;
        // Descending scan leaves the lowest-index hit in each layer.
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (hit[i] && ABOVE_BEAN[i]) begin
                a_found = 1'b1;
                a_idx   = IDX_W'(i);
                a_loc   = loc[i];
            end
            if (hit[i] && !ABOVE_BEAN[i]) begin
                b_found = 1'b1;
                b_idx   = IDX_W'(i);
                b_loc   = loc[i];
            end
        end

        rom_addr_d = '0;
        if (over)         cls_d = CLS_BLACK;
        else if (is_wall) cls_d = CLS_WALL;
        else if (a_found) begin
            cls_d      = CLS_SPR;
            rom_addr_d = {a_idx, a_loc};
        end
        else if (is_bean) cls_d = CLS_BEAN;
        else if (b_found) begin
            cls_d      = CLS_SPR;
            rom_addr_d = {b_idx, b_loc};
        end
        else              cls_d = CLS_BLACK;

        coll_set = '0;
        if (pix_valid && !over && !is_wall && hit[0]) begin
            for (int i = 1; i < NUM_SPR; i++) coll_set[i] = hit[i];
        end
        // A fresh overlap survives a coincident frame_start clear.
        collide_d = (frame_start ? '0 : collide_q) | coll_set;

        vga_data_d = '0;
        if (vld2_q) begin
            case (cls2_q)
                CLS_WALL: vga_data_d = WALL_COLOR;
                CLS_BEAN: vga_data_d = BEAN_COLOR;
                CLS_SPR:  vga_data_d = (rom_data == KEY_COLOR)
                                       ? (bean2_q ? BEAN_COLOR : '0) : rom_data;
                default:  vga_data_d = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sx_q        <= '0;
            sy_q        <= '0;
            so_q        <= '0;
            se_q        <= '0;
            cls1_q      <= CLS_BLACK;
            cls2_q      <= CLS_BLACK;
            vld1_q      <= 1'b0;
            vld2_q      <= 1'b0;
            bean1_q     <= 1'b0;
            bean2_q     <= 1'b0;
            rom_addr_q  <= '0;
            collide_q   <= '0;
            vga_data_q  <= '0;
            vga_valid_q <= 1'b0;
        end else begin
            if (frame_start) begin
                sx_q <= spr_x;
                sy_q <= spr_y;
                so_q <= spr_orient;
                se_q <= spr_en;
            end
            cls1_q      <= cls_d;
            vld1_q      <= pix_valid;
            bean1_q     <= is_bean;
            rom_addr_q  <= rom_addr_d;
            cls2_q      <= cls1_q;
            vld2_q      <= vld1_q;
            bean2_q     <= bean1_q;
            collide_q   <= collide_d;
            vga_data_q  <= vga_data_d;
            vga_valid_q <= vld2_q;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign vga_data  = vga_data_q;
    assign vga_valid = vga_valid_q;
    assign collide   = collide_q;

endmodule
